// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding and frame constants for the program loader.
// Revision: 1.0
`default_nettype none

package loader_pkg;

  localparam int INSTR_WIDTH_DEFAULT = 9;

  // Bits of the high frame byte that must be zero; only bit 0 carries instr[8].
  localparam logic [7:0] HI_PAD_MASK = 8'hFE;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LO   = 3'd1,
    HI   = 3'd2,
    WR   = 3'd3,
    CHK  = 3'd4,
    DONE = 3'd5
  } state_e;

endpackage

`default_nettype wire

// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream input handshake and instruction-memory write port.
// Revision: 1.0
`default_nettype none

interface prog_loader_if #(
  parameter int AW          = 8,
  parameter int INSTR_WIDTH = 9
);

  logic [7:0]             in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic [INSTR_WIDTH-1:0] wr_data;

  modport master (
    input  in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data
  );

endinterface

`default_nettype wire

// File: rtl/prog_loader.sv
// prog_loader: assembles 9-bit instructions from byte pairs and writes them to
// instruction memory from address 0. Optional trailer checksum: LOADER_CHECKSUM_EN.
// Revision: 1.0
`default_nettype none

module prog_loader
  import loader_pkg::*;
#(
  parameter  int ROM_SIZE    = 256,
  parameter  int INSTR_WIDTH = INSTR_WIDTH_DEFAULT,
  localparam int AW          = $clog2(ROM_SIZE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW:0]   len,
  prog_loader_if.master bus,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [AW:0] ROM_SIZE_W = (AW+1)'(ROM_SIZE);

  state_e                 state_q, state_d;
  logic [AW-1:0]          wr_addr_q, wr_addr_d;
  logic [AW:0]            len_q, len_d;
  logic [7:0]             lo_q, lo_d;
  logic [INSTR_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                   err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]             xor_q, xor_d;
`endif

  logic        w_accept;
  logic [AW:0] w_len_sat;
  logic [AW:0] w_next_addr;
  state_e      w_after_words;

  assign bus.in_ready = (state_q == LO) || (state_q == HI) || (state_q == CHK);
  assign bus.wr_en    = (state_q == WR);
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign busy         = (state_q != IDLE);
  assign cpu_hold     = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign err          = err_q;

  assign w_accept    = bus.in_valid && bus.in_ready;
  assign w_len_sat   = (len > ROM_SIZE_W) ? ROM_SIZE_W : len;
  assign w_next_addr = {1'b0, wr_addr_q} + {{AW{1'b0}}, 1'b1};
`ifdef LOADER_CHECKSUM_EN
  assign w_after_words = CHK;
`else
  assign w_after_words = DONE;
`endif

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    len_d     = len_q;
    lo_d      = lo_q;
    wr_data_d = wr_data_q;
    err_d     = err_q;
`ifdef LOADER_CHECKSUM_EN
    xor_d     = xor_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d     = w_len_sat;
          wr_addr_d = '0;
          err_d     = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          xor_d     = 8'h00;
`endif
          state_d   = (w_len_sat == '0) ? w_after_words : LO;
        end
      end
      LO: begin
        if (w_accept) begin
          lo_d    = bus.in_data;
`ifdef LOADER_CHECKSUM_EN
          xor_d   = xor_q ^ bus.in_data;
`endif
          state_d = HI;
        end
      end
      HI: begin
        if (w_accept) begin
          wr_data_d = {bus.in_data[0], lo_q};
          if ((bus.in_data & HI_PAD_MASK) != 8'h00) err_d = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          xor_d     = xor_q ^ bus.in_data;
`endif
          state_d   = WR;
        end
      end
      WR: begin
        // The address advances past the last word unless that would wrap.
        if (w_next_addr < len_q) begin
          wr_addr_d = w_next_addr[AW-1:0];
          state_d   = LO;
        end else begin
          if (w_next_addr < ROM_SIZE_W) wr_addr_d = w_next_addr[AW-1:0];
          state_d = w_after_words;
        end
      end
      CHK: begin
        if (w_accept) begin
`ifdef LOADER_CHECKSUM_EN
          if (bus.in_data != xor_q) err_d = 1'b1;
`endif
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_addr_q <= '0;
      len_q     <= '0;
      lo_q      <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      xor_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      len_q     <= len_d;
      lo_q      <= lo_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
`ifdef LOADER_CHECKSUM_EN
      xor_q     <= xor_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized and directed bench for prog_loader against a
// byte-count based behavioural model.
`default_nettype none

module tb_prog_loader;

  localparam int ROM_SIZE = 256;
  localparam int AW       = 8;
  localparam int IW       = 9;
`ifdef LOADER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   len;
  logic          cpu_hold, busy, done, err;

  prog_loader_if #(.AW(AW), .INSTR_WIDTH(IW)) bus ();

  prog_loader #(.ROM_SIZE(ROM_SIZE), .INSTR_WIDTH(IW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .len      (len),
    .bus      (bus.master),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int fail_prints = 0;
  bit cmp_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model: outputs follow from how many bytes of the load have
  // been accepted and whether a write or completion is owed.
  bit         m_ready, m_wr, m_busy, m_done, m_err;
  int         m_addr;
  logic [8:0] m_data;
  int         n_words, need, acc, wrote;
  logic [7:0] m_lo, m_xr, mb;

  initial begin
    m_ready = 0; m_wr = 0; m_busy = 0; m_done = 0; m_err = 0;
    m_addr = 0; m_data = '0; n_words = 0; need = 0; acc = 0; wrote = 0;
    m_lo = 0; m_xr = 0;
  end

  always @(posedge clk) begin
    if (reset) begin
      m_ready = 0; m_wr = 0; m_busy = 0; m_done = 0; m_err = 0;
      m_addr = 0; m_data = '0;
    end else if (!m_busy) begin
      if (start) begin
        n_words = (int'(len) > ROM_SIZE) ? ROM_SIZE : int'(len);
        need    = 2 * n_words + CK;
        acc = 0; wrote = 0; m_xr = 8'h00; m_err = 0; m_addr = 0; m_busy = 1;
        if (need == 0) m_done = 1;
        else           m_ready = 1;
      end
    end else if (m_done) begin
      m_busy = 0; m_done = 0;
    end else if (m_wr) begin
      m_wr = 0;
      wrote++;
      m_addr = (wrote < ROM_SIZE) ? wrote : ROM_SIZE - 1;
      if (acc < need) m_ready = 1;
      else            m_done = 1;
    end else if (m_ready && bus.in_valid) begin
      mb = bus.in_data;
      acc++;
      if (acc <= 2 * n_words) begin
        m_xr = m_xr ^ mb;
        if (acc % 2 == 1) begin
          m_lo = mb;
        end else begin
          m_data  = {mb[0], m_lo};
          if (mb[7:1] != 7'd0) m_err = 1;
          m_ready = 0;
          m_wr    = 1;
        end
      end else begin
        if (mb != m_xr) m_err = 1;
        m_ready = 0;
        m_done  = 1;
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  logic [22:0] v_dut, v_mod;
  always @(negedge clk) begin
    if (cmp_en) begin
      v_dut = {bus.in_ready, bus.wr_en, bus.wr_addr, bus.wr_data, cpu_hold, busy, done, err};
      v_mod = {m_ready, m_wr, AW'(m_addr), m_data, m_busy, m_busy, m_done, m_err};
      checks++;
      if (v_dut !== v_mod) begin
        errors++;
        if (fail_prints < 40) begin
          fail_prints++;
          $display("FAIL cycle_compare cyc=%0d got rdy/wr/addr/data/hold/busy/done/err=%h required=%h",
                   cyc, v_dut, v_mod);
        end
      end
    end
  end

  // Write log captured from the memory port.
  int wa[$];
  int wd[$];
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      wa.push_back(int'(bus.wr_addr));
      wd.push_back(int'(bus.wr_data));
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] xor_all(input logic [7:0] b[$]);
    logic [7:0] x = 8'h00;
    foreach (b[i]) x = x ^ b[i];
    return x;
  endfunction

  function automatic bit pick_valid(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (k % 2) == 0;
    return $urandom_range(0, 3) != 0;
  endfunction

  // Pulses start, feeds bytes under the chosen valid pattern until done.
  task automatic run_load(input int n, input logic [7:0] b[$], input int mode,
                          input bit noise, output int done_off);
    int idx = 0;
    int t0;
    bit acc_b;
    bit seen = 0;
    done_off = -1;
    start = 1'b1;
    len   = (AW+1)'(n);
    bus.in_valid = pick_valid(mode, 0);
    bus.in_data  = (b.size() > 0) ? b[0] : 8'($urandom);
    t0 = cyc;
    for (int k = 1; k < 4000 && !seen; k++) begin
      @(negedge clk);
      acc_b = bus.in_valid && bus.in_ready;
      if (done === 1'b1) begin
        seen = 1;
        done_off = cyc - t0;
      end
      @(posedge clk);
      #1;
      start = noise && !seen && ($urandom_range(0, 15) == 0);
      len   = (AW+1)'($urandom);
      if (acc_b) idx++;
      bus.in_valid = pick_valid(mode, k);
      bus.in_data  = (idx < b.size()) ? b[idx] : 8'($urandom);
    end
    start = 1'b0;
    if (!seen) check("load_timeout_done_seen", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.in_valid = $urandom_range(0, 1);
      bus.in_data  = 8'($urandom);
    end
  endtask

  initial begin
    logic [7:0] q[$];
    int doff;
    int n, k;

    reset = 1'b1; start = 1'b0; len = '0;
    bus.in_valid = 1'b0; bus.in_data = 8'h00;
    @(posedge clk);
    #1 cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_outputs",
          int'({bus.in_ready, bus.wr_en, bus.wr_addr, bus.wr_data, cpu_hold, busy, done, err}), 0);
    idle(3);

    // Back-to-back load of three words.
    wa.delete(); wd.delete();
    q = {8'hC0, 8'h00, 8'h43, 8'h01, 8'hC6, 8'h00};
    if (CK != 0) q.push_back(xor_all(q));
    run_load(3, q, 0, 1'b0, doff);
    check("b2b_nwrites", wa.size(), 3);
    if (wa.size() == 3) begin
      check("b2b_w0", (wa[0] << 12) | wd[0], 32'h0000_00C0);
      check("b2b_w1", (wa[1] << 12) | wd[1], 32'h0000_1143);
      check("b2b_w2", (wa[2] << 12) | wd[2], 32'h0000_20C6);
    end
    check("b2b_done_cycle", doff, 10 + CK);
    check("b2b_err", int'(err), 0);
    idle(2);

    // Framing error: nonzero padding still writes {byte1[0], lo}; err sticks.
    wa.delete(); wd.delete();
    q = {8'h55, 8'h03};
    if (CK != 0) q.push_back(xor_all(q));
    run_load(1, q, 0, 1'b0, doff);
    check("frame_nwrites", wa.size(), 1);
    if (wa.size() == 1) check("frame_data", wd[0], 32'h155);
    idle(5);
    check("frame_err_sticky", int'(err), 1);

    // Alternating valid: same words, no drops or duplicates; err cleared by start.
    wa.delete(); wd.delete();
    q = {8'hC0, 8'h00, 8'h43, 8'h01};
    if (CK != 0) q.push_back(xor_all(q));
    run_load(2, q, 1, 1'b0, doff);
    check("stall_nwrites", wa.size(), 2);
    if (wa.size() == 2) begin
      check("stall_w0", wd[0], 32'h0C0);
      check("stall_w1", wd[1], 32'h143);
    end
    check("stall_err_cleared", int'(err), 0);
    idle(2);

    // Zero-length load.
    wa.delete(); wd.delete();
    q = {};
    if (CK != 0) q.push_back(8'h00);
    run_load(0, q, 0, 1'b0, doff);
    check("len0_nwrites", wa.size(), 0);
    check("len0_done_cycle", doff, 1 + CK);
    idle(2);

    // Oversized length saturates at the memory depth.
    wa.delete(); wd.delete();
    q = {};
    for (int i = 0; i < 2 * ROM_SIZE; i++) q.push_back(8'($urandom_range(0, 255)) & ((i % 2) ? 8'h01 : 8'hFF));
    if (CK != 0) q.push_back(xor_all(q));
    run_load(300, q, 0, 1'b1, doff);
    check("sat_nwrites", wa.size(), ROM_SIZE);
    if (wa.size() == ROM_SIZE) begin
      check("sat_last_addr", wa[ROM_SIZE-1], ROM_SIZE - 1);
      check("sat_last_data", wd[ROM_SIZE-1], int'({q[2*ROM_SIZE-1][0], q[2*ROM_SIZE-2]}));
    end
    idle(2);

    // Reset after the second write of a five-word load.
    wa.delete(); wd.delete();
    start = 1'b1; len = 9'd5; bus.in_valid = 1'b1; bus.in_data = 8'h21;
    @(posedge clk); #1 start = 1'b0;
    k = 0;
    while (wa.size() < 2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) check("midreset_timeout_2writes", wa.size(), 2);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("midreset_outputs",
          int'({bus.in_ready, bus.wr_en, bus.wr_addr, bus.wr_data, cpu_hold, busy, done, err}), 0);
    idle(1);
    wa.delete(); wd.delete();
    q = {8'h11, 8'h01, 8'h22, 8'h00};
    if (CK != 0) q.push_back(xor_all(q));
    run_load(2, q, 2, 1'b0, doff);
    check("midreset_restart_nwrites", wa.size(), 2);
    if (wa.size() == 2) check("midreset_restart_addr0", (wa[0] << 12) | wd[0], 32'h111);
    idle(2);

`ifdef LOADER_CHECKSUM_EN
    q = {8'h12, 8'h01, 8'h13};
    run_load(1, q, 0, 1'b0, doff);
    check("ck_good_done", int'(doff > 0), 1);
    check("ck_good_err", int'(err), 0);
    idle(2);
    q = {8'h12, 8'h01, 8'h00};
    run_load(1, q, 0, 1'b0, doff);
    check("ck_bad_done", int'(doff > 0), 1);
    check("ck_bad_err", int'(err), 1);
    idle(2);
`endif

    // Randomized loads; the cycle compare does the checking.
    for (int r = 0; r < 30; r++) begin
      n = ($urandom_range(0, 9) == 0) ? $urandom_range(250, 300) : $urandom_range(0, 12);
      q = {};
      for (int i = 0; i < 2 * n; i++) begin
        if (i % 2 == 0)                    q.push_back(8'($urandom));
        else if ($urandom_range(0, 7) == 0) q.push_back(8'($urandom));
        else                                q.push_back(8'($urandom_range(0, 1)));
      end
      if (CK != 0) q.push_back(($urandom_range(0, 3) == 0) ? 8'($urandom) : xor_all(q));
      run_load(n, q, (n > 20) ? 0 : 2, 1'b1, doff);
      idle($urandom_range(0, 4));
    end

    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
